// File: rtl/jtframe_db9_joy.sv
// DB9 pad scanner: drives the shared select line through the 8-phase Mega Drive sequence and detects Atari/MD3/MD6 pads per port.
// Latency: joy_out/pad_type commit once per scan (IDLE_CYC + 8*PHASE_CYC cycles); pins see SYNC_STAGES of synchronisation.
// Backpressure: none; outputs hold the last committed scan, and scan_done pulses for one cycle on each update.
module jtframe_db9_joy #(
  parameter int NPORTS      = 2,
  parameter int PHASE_CYC   = 480,
  parameter int IDLE_CYC    = 96000,
  parameter int SYNC_STAGES = 2
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NPORTS-1:0]     db9_up,
  input  logic [NPORTS-1:0]     db9_down,
  input  logic [NPORTS-1:0]     db9_left,
  input  logic [NPORTS-1:0]     db9_right,
  input  logic [NPORTS-1:0]     db9_p6,
  input  logic [NPORTS-1:0]     db9_p9,
  input  logic [NPORTS-1:0]     force_atari,
  output logic                  db9_sel,
  output logic [12*NPORTS-1:0]  joy_out,
  output logic [2*NPORTS-1:0]   pad_type,
  output logic                  scan_done
);
  localparam int MAX_CYC = (IDLE_CYC > PHASE_CYC) ? IDLE_CYC : PHASE_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int PW      = 6 * NPORTS;

  typedef enum logic [3:0] {
    PH0, PH1, PH2, PH3, PH4, PH5, PH6, PH7, IDLE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            last;
  logic [PW-1:0]   sync_q [SYNC_STAGES];

  logic [NPORTS-1:0] s_up, s_down, s_left, s_right, s_p6, s_p9;
  logic [NPORTS-1:0] sh_u, sh_d, sh_l, sh_r, sh_a, sh_b, sh_c, sh_st;
  logic [NPORTS-1:0] sh_x, sh_y, sh_z, sh_mode, md_id, six_id;

  // Pins idle high, so the synchroniser resets to the "nothing pressed" level
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
    end else begin
      sync_q[0] <= {db9_p9, db9_p6, db9_up, db9_down, db9_left, db9_right};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s_right = sync_q[SYNC_STAGES-1][0*NPORTS +: NPORTS];
  assign s_left  = sync_q[SYNC_STAGES-1][1*NPORTS +: NPORTS];
  assign s_down  = sync_q[SYNC_STAGES-1][2*NPORTS +: NPORTS];
  assign s_up    = sync_q[SYNC_STAGES-1][3*NPORTS +: NPORTS];
  assign s_p6    = sync_q[SYNC_STAGES-1][4*NPORTS +: NPORTS];
  assign s_p9    = sync_q[SYNC_STAGES-1][5*NPORTS +: NPORTS];

  assign last = (state == IDLE) ? (cnt == CW'(IDLE_CYC - 1)) : (cnt == CW'(PHASE_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      db9_sel   <= 1'b1;
      joy_out   <= '1;
      pad_type  <= '0;
      scan_done <= 1'b0;
      sh_u <= '1; sh_d <= '1; sh_l <= '1; sh_r <= '1;
      sh_a <= '1; sh_b <= '1; sh_c <= '1; sh_st <= '1;
      sh_x <= '1; sh_y <= '1; sh_z <= '1; sh_mode <= '1;
      md_id  <= '0;
      six_id <= '0;
    end else begin
      scan_done <= 1'b0;
      if (!last) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
        // Select is high in even phases, so the next phase is even exactly when this one is odd
        case (state)
          IDLE:    begin state <= PH0;  db9_sel <= 1'b1; end
          PH7:     begin state <= IDLE; db9_sel <= 1'b1; scan_done <= 1'b1; end
          default: begin state <= state_t'(state + 4'd1); db9_sel <= state[0]; end
        endcase

        case (state)
          PH0: begin
            sh_u <= s_up; sh_d <= s_down; sh_l <= s_left; sh_r <= s_right;
            sh_b <= s_p6; sh_c <= s_p9;
          end
          PH1: begin
            md_id <= ~s_left & ~s_right;
            sh_a  <= s_p6;
            sh_st <= s_p9;
          end
          PH5: six_id <= ~(s_up | s_down | s_left | s_right);
          PH6: begin
            sh_z <= s_up; sh_y <= s_down; sh_x <= s_left; sh_mode <= s_right;
          end
          default: ;
        endcase

        if (state == PH7) begin
          for (int p = 0; p < NPORTS; p++) begin
            if (force_atari[p] || !md_id[p]) begin
              pad_type[2*p +: 2] <= 2'b00;
              joy_out[12*p +: 12] <= {6'h3F, sh_c[p], sh_b[p], sh_u[p], sh_d[p], sh_l[p], sh_r[p]};
            end else if (!six_id[p]) begin
              pad_type[2*p +: 2] <= 2'b01;
              joy_out[12*p +: 12] <= {1'b1, sh_st[p], 3'b111, sh_c[p], sh_b[p], sh_a[p],
                                      sh_u[p], sh_d[p], sh_l[p], sh_r[p]};
            end else begin
              pad_type[2*p +: 2] <= 2'b10;
              joy_out[12*p +: 12] <= {sh_mode[p], sh_st[p], sh_z[p], sh_y[p], sh_x[p],
                                      sh_c[p], sh_b[p], sh_a[p],
                                      sh_u[p], sh_d[p], sh_l[p], sh_r[p]};
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jtframe_db9_joy.sv
// Bench for jtframe_db9_joy: behavioural pad models on the pins, a scan-period model of the outputs,
// and directed scenarios with hand-computed joystick words.
module tb_jtframe_db9_joy;
  localparam int NP   = 2;
  localparam int PC   = 4;
  localparam int IC   = 20;
  localparam int SS   = 2;
  localparam int SCAN = IC + 8 * PC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NP-1:0]    db9_up, db9_down, db9_left, db9_right, db9_p6, db9_p9;
  logic [NP-1:0]    force_atari;
  logic             db9_sel;
  logic [12*NP-1:0] joy_out;
  logic [2*NP-1:0]  pad_type;
  logic             scan_done;

  jtframe_db9_joy #(
    .NPORTS(NP), .PHASE_CYC(PC), .IDLE_CYC(IC), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .rst(rst),
    .db9_up(db9_up), .db9_down(db9_down), .db9_left(db9_left), .db9_right(db9_right),
    .db9_p6(db9_p6), .db9_p9(db9_p9), .force_atari(force_atari),
    .db9_sel(db9_sel), .joy_out(joy_out), .pad_type(pad_type), .scan_done(scan_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Pad models. kind: 0 Atari/unplugged, 1 MD3, 2 MD6. pr: pressed buttons in joy_out bit order.
  int          kind [NP];
  logic [11:0] pr   [NP];
  int          n_fall = 0;
  int          hi_cnt = 0;
  logic        prev_sel = 1'b1;

  // An MD6 pad counts select falls and forgets them after a long select-high gap
  always @(negedge clk) begin
    if (prev_sel && !db9_sel) n_fall <= n_fall + 1;
    else if (hi_cnt >= 10)    n_fall <= 0;
    hi_cnt   <= db9_sel ? hi_cnt + 1 : 0;
    prev_sel <= db9_sel;
  end

  always_comb begin
    db9_up = '1; db9_down = '1; db9_left = '1; db9_right = '1; db9_p6 = '1; db9_p9 = '1;
    for (int p = 0; p < NP; p++) begin
      if (kind[p] == 0) begin
        db9_right[p] = ~pr[p][0]; db9_left[p] = ~pr[p][1];
        db9_down[p]  = ~pr[p][2]; db9_up[p]   = ~pr[p][3];
        db9_p6[p]    = ~pr[p][4]; db9_p9[p]   = ~pr[p][5];
      end else if (db9_sel) begin
        if (kind[p] == 2 && n_fall == 3) begin
          db9_up[p] = ~pr[p][9]; db9_down[p] = ~pr[p][8];
          db9_left[p] = ~pr[p][7]; db9_right[p] = ~pr[p][11];
        end else begin
          db9_up[p] = ~pr[p][3]; db9_down[p] = ~pr[p][2];
          db9_left[p] = ~pr[p][1]; db9_right[p] = ~pr[p][0];
        end
        db9_p6[p] = ~pr[p][5];
        db9_p9[p] = ~pr[p][6];
      end else begin
        if (kind[p] == 2 && n_fall == 3) begin
          db9_up[p] = 1'b0; db9_down[p] = 1'b0; db9_left[p] = 1'b0; db9_right[p] = 1'b0;
        end else if (kind[p] == 2 && n_fall == 4) begin
          db9_up[p] = 1'b1; db9_down[p] = 1'b1; db9_left[p] = 1'b1; db9_right[p] = 1'b1;
        end else begin
          db9_up[p] = ~pr[p][3]; db9_down[p] = ~pr[p][2];
          db9_left[p] = 1'b0; db9_right[p] = 1'b0;
        end
        db9_p6[p] = ~pr[p][4];
        db9_p9[p] = ~pr[p][10];
      end
    end
  end

  // What a scan must report for a given pad: {type, active-low word}
  function automatic logic [13:0] pad_expect(input int k, input logic [11:0] b, input logic f);
    if (k == 0) return {2'b00, ~(b & 12'h03F)};
    if (f)      return {2'b00, ~{6'b0, b[6], b[5], b[3:0]}};
    if (k == 1) return {2'b01, ~(b & 12'h47F)};
    return {2'b10, ~b};
  endfunction

  // Output model: a commit every SCAN cycles after reset release
  int               t = 0;
  logic [12*NP-1:0] exp_joy  = '1;
  logic [2*NP-1:0]  exp_type = '0;
  logic             exp_done = 1'b0;
  logic [13:0]      r;

  always @(posedge clk) begin
    if (rst) begin
      t <= 0; exp_joy <= '1; exp_type <= '0; exp_done <= 1'b0;
    end else begin
      t <= t + 1;
      exp_done <= ((t + 1) % SCAN == 0);
      if ((t + 1) % SCAN == 0) begin
        for (int p = 0; p < NP; p++) begin
          r = pad_expect(kind[p], pr[p], force_atari[p]);
          exp_joy[12*p +: 12] <= r[11:0];
          exp_type[2*p +: 2]  <= r[13:12];
        end
      end
    end
  end

  always @(negedge clk) begin
    int   o;
    logic es;
    o  = t % SCAN;
    es = (o < IC) || (((o - IC) / PC) % 2 == 0);
    check("sel", {31'b0, db9_sel}, {31'b0, es});
    check("joy_out", {8'b0, joy_out}, {8'b0, exp_joy});
    check("pad_type", {28'b0, pad_type}, {28'b0, exp_type});
    check("scan_done", {31'b0, scan_done}, {31'b0, exp_done});
  end

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!scan_done && cyc < 200);
    if (!scan_done) check("scan_done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int c, pulses, wide;
    logic prev;
    for (int p = 0; p < NP; p++) begin kind[p] = 0; pr[p] = '0; end
    force_atari = '0;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_sel", {31'b0, db9_sel}, 32'd1);
    check("rst_joy", {8'b0, joy_out}, 32'hFFFFFF);
    check("rst_type", {28'b0, pad_type}, 32'd0);
    rst = 1'b0;
    wait_done(c);
    check("first_done_latency", c, 32'd52);

    // Atari on port 0 with fire1+up, MD3 on port 1 with A+Start
    kind[0] = 0; pr[0] = 12'h018;
    kind[1] = 1; pr[1] = 12'h410;
    wait_done(c);
    check("atari_joy", {20'b0, joy_out[11:0]}, 32'hFE7);
    check("atari_type", {30'b0, pad_type[1:0]}, 32'd0);
    check("md3_joy", {20'b0, joy_out[23:12]}, 32'hBEF);
    check("md3_type", {30'b0, pad_type[3:2]}, 32'd1);

    // MD6 on port 0 with X+Mode, port 1 unplugged
    kind[0] = 2; pr[0] = 12'h880;
    kind[1] = 0; pr[1] = '0;
    wait_done(c);
    check("md6_joy", {20'b0, joy_out[11:0]}, 32'h77F);
    check("md6_type", {30'b0, pad_type[1:0]}, 32'd2);
    check("unplug_joy", {20'b0, joy_out[23:12]}, 32'hFFF);

    force_atari[0] = 1'b1;
    wait_done(c);
    check("forced_joy", {20'b0, joy_out[11:0]}, 32'hFFF);
    check("forced_type", {30'b0, pad_type[1:0]}, 32'd0);

    // Clearing force mid-scan affects the commit at the end of that scan
    repeat (30) @(negedge clk);
    force_atari[0] = 1'b0;
    wait_done(c);
    check("unforce_type", {30'b0, pad_type[1:0]}, 32'd2);

    // Reset pulse in PH3 aborts the scan
    repeat (33) @(negedge clk);
    check("ph3_sel", {31'b0, db9_sel}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_sel", {31'b0, db9_sel}, 32'd1);
    check("abort_joy", {8'b0, joy_out}, 32'hFFFFFF);
    wait_done(c);
    check("abort_done_latency", c, 32'd52);
    check("after_abort_joy", {20'b0, joy_out[11:0]}, 32'h77F);

    // Both ports unplugged for three scans
    kind[0] = 0; pr[0] = '0;
    pulses = 0; wide = 0; prev = 1'b1;
    for (int i = 0; i < 3 * SCAN; i++) begin
      @(negedge clk);
      if (scan_done) begin
        pulses++;
        if (prev) wide++;
      end
      prev = scan_done;
    end
    check("unplug_pulses", pulses, 32'd3);
    check("unplug_wide", wide, 32'd0);
    check("unplug_all_joy", {8'b0, joy_out}, 32'hFFFFFF);
    check("unplug_all_type", {28'b0, pad_type}, 32'd0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
